rf_param_sb: RTL and testbench

//  Parametrised general-purpose register file for the MIPS datapath: N async read ports, one sync write port.

---
 rtl/rf_param_sb.sv | 109 ++++++++++
 tb/tb_rf_param_sb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_param_sb.sv
// rf_param_sb: parametrised register file with N async read ports, one sync write port,
// sequential clear after reset, per-entry pending scoreboard; macro RF_BYPASS_EN adds write bypass.
module rf_param_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_pending,
  input  logic                     i_reg_write,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_sb_set,
  input  logic [ADDR_W-1:0]        i_sb_addr,
  output logic                     o_init_done
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W:0]   r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic              w_run;
  logic              w_last;
  logic              w_wr_en;
  logic              w_sb_en;

  assign w_last  = (r_clr_cnt == (ADDR_W + 1)'(DEPTH - 1));
  assign w_wr_en = w_run && i_reg_write && !(ZERO_REG && (i_wr_addr == '0));
  assign w_sb_en = w_run && i_sb_set && !(ZERO_REG && (i_sb_addr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StClear;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StClear: if (w_last) w_state_d = StRun;
      StRun:   w_state_d = StRun;
      default: w_state_d = StClear;
    endcase
  end

  always_comb begin
    w_run       = (r_state == StRun);
    o_init_done = w_run;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clr_cnt <= '0;
    end else if (r_state == StClear) begin
      r_clr_cnt <= r_clr_cnt + (ADDR_W + 1)'(1);
    end
  end

  // Storage has no reset of its own; the clear engine zeroes it one entry per cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (!w_run) begin
        r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (w_wr_en) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Set is applied after clear so a newly issued producer wins on the same entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
    end else begin
      if (w_wr_en) r_pend[i_wr_addr] <= 1'b0;
      if (w_sb_en) r_pend[i_sb_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_mask;
    logic              w_byp;

    assign w_ra   = i_rd_addr[g*ADDR_W +: ADDR_W];
    assign w_mask = !w_run || (ZERO_REG && (w_ra == '0));
`ifdef RF_BYPASS_EN
    assign w_byp  = w_wr_en && (i_wr_addr == w_ra);
`else
    assign w_byp  = 1'b0;
`endif

    assign o_rd_data[g*DATA_W +: DATA_W] = w_mask ? '0 :
                                           w_byp  ? i_wr_data : r_mem[w_ra];
    assign o_rd_pending[g] = w_mask ? 1'b0 :
                             w_byp  ? (w_sb_en && (i_sb_addr == w_ra)) : r_pend[w_ra];
  end

endmodule

// File: tb/tb_rf_param_sb.sv
// Bench for rf_param_sb: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the file; second instance covers the 64x16, 3-port variant.
module tb_rf_param_sb;
  localparam int unsigned DW = 32, AW = 5, NR = 2, DEPTH = 32;
  localparam int unsigned BDW = 64, BAW = 4, BNR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, we, sb, done;
  logic [AW-1:0]    wa, sa;
  logic [DW-1:0]    wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rpend;

  logic               b_rst, b_we, b_sb, b_done;
  logic [BAW-1:0]     b_wa, b_sa;
  logic [BDW-1:0]     b_wd;
  logic [BNR*BAW-1:0] b_ra;
  logic [BNR*BDW-1:0] b_rdata;
  logic [BNR-1:0]     b_rpend;

  rf_param_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(ra), .o_rd_data(rdata), .o_rd_pending(rpend),
    .i_reg_write(we), .i_wr_addr(wa), .i_wr_data(wd), .i_sb_set(sb), .i_sb_addr(sa),
    .o_init_done(done)
  );

  rf_param_sb #(.DATA_W(BDW), .ADDR_W(BAW), .NUM_RD(BNR), .ZERO_REG(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_rd_addr(b_ra), .o_rd_data(b_rdata), .o_rd_pending(b_rpend),
    .i_reg_write(b_we), .i_wr_addr(b_wa), .i_wr_data(b_wd), .i_sb_set(b_sb), .i_sb_addr(b_sa),
    .o_init_done(b_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents, pending set, cycles elapsed since reset.
  logic [DW-1:0]    m_reg [DEPTH];
  bit   [DEPTH-1:0] m_pend;
  int               m_since = 0;
  bit               m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_since = 0;
      m_pend  = '0;
    end else if (m_known) begin
      if (m_since < DEPTH) begin
        m_reg[m_since] = '0;
        m_since++;
      end else begin
        if (we && wa != 0) m_reg[wa] = wd;
        if (we) m_pend[wa] = 1'b0;
        if (sb && sa != 0) m_pend[sa] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit            run;
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          ep;
    if (m_known) begin
      run = (m_since == DEPTH);
      chk("init_done", done, run);
      for (int i = 0; i < NR; i++) begin
        a  = ra[i*AW +: AW];
        ed = '0;
        ep = 1'b0;
        if (run && a != 0) begin
          ed = m_reg[a];
          ep = m_pend[a];
`ifdef RF_BYPASS_EN
          if (we && wa == a) begin
            ed = wd;
            ep = sb && (sa == a);
          end
`endif
        end
        chk($sformatf("rd_data[%0d]", i), rdata[i*DW +: DW], ed);
        chk($sformatf("rd_pending[%0d]", i), rpend[i], ep);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    while (!b_done && n < 200) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom());
  endfunction

  task automatic check_all_zero(input string name);
    for (int r = 0; r < DEPTH; r += 2) begin
      set_rd(0, AW'(r));
      set_rd(1, AW'(r + 1));
      #1;
      chk({name, "_data"}, rdata, '0);
      chk({name, "_pend"}, rpend, '0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; sb = 1'b0; wa = '0; sa = '0; wd = '0; ra = '0;
    b_rst = 1'b1; b_we = 1'b0; b_sb = 1'b0; b_wa = '0; b_sa = '0; b_wd = '0; b_ra = '0;
    tick();
    tick();
    rst = 1'b0;
    wait_done(n);
    chk("t1_first_clear_cycles", 64'(n), 64'd32);

    // T1: fill with garbage and pending, then reset with writes attempted during the clear
    for (int r = 0; r < DEPTH; r++) begin
      we = 1'b1; wa = AW'(r); wd = $urandom();
      sb = 1'b1; sa = AW'((r + 3) % DEPTH);
      tick();
    end
    we = 1'b0; sb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; wa = AW'(3); wd = 32'hAAAA_5555; sb = 1'b1; sa = AW'(3);
    wait_done(n);
    we = 1'b0; sb = 1'b0;
    chk("t1_clear_cycles", 64'(n), 64'd32);
    check_all_zero("t1_reg");

    // T2: write/read, both ports on one address, r0 hardwired
    we = 1'b1; wa = AW'(5); wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    set_rd(0, AW'(5)); set_rd(1, AW'(5));
    #1;
    chk("t2_port0", rdata[DW-1:0], 32'hDEAD_BEEF);
    chk("t2_port1", rdata[2*DW-1:DW], 32'hDEAD_BEEF);
    we = 1'b1; wa = '0; wd = 32'h1234;
    tick();
    we = 1'b0;
    set_rd(0, '0);
    #1;
    chk("t2_r0", rdata[DW-1:0], 32'h0);

    // T3: scoreboard set, clear, set-wins
    sb = 1'b1; sa = AW'(7);
    tick();
    sb = 1'b0;
    set_rd(0, AW'(7));
    #1;
    chk("t3_set", rpend[0], 1'b1);
    we = 1'b1; wa = AW'(7); wd = 32'h77;
    tick();
    we = 1'b0;
    #1;
    chk("t3_clear", rpend[0], 1'b0);
    chk("t3_data", rdata[DW-1:0], 32'h77);
    we = 1'b1; sb = 1'b1; wa = AW'(7); sa = AW'(7); wd = 32'h88;
    tick();
    we = 1'b0; sb = 1'b0;
    #1;
    chk("t3_set_wins", rpend[0], 1'b1);
    chk("t3_data2", rdata[DW-1:0], 32'h88);

    // T4: same-cycle write and read
    we = 1'b1; wa = AW'(9); wd = 32'h11;
    tick();
    wd = 32'h22;
    set_rd(0, AW'(9));
    #1;
`ifdef RF_BYPASS_EN
    chk("t4_same_cycle", rdata[DW-1:0], 32'h22);
`else
    chk("t4_same_cycle", rdata[DW-1:0], 32'h11);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("t4_next_cycle", rdata[DW-1:0], 32'h22);

    // Randomized traffic with occasional resets; the compare process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      we  = ($urandom_range(0, 1) == 1);
      sb  = ($urandom_range(0, 3) == 0);
      wa  = rand_addr();
      sa  = rand_addr();
      wd  = $urandom();
      set_rd(0, rand_addr());
      set_rd(1, rand_addr());
      tick();
    end
    rst = 1'b0; we = 1'b0; sb = 1'b0;

    // T5: reset again at clear cycle 10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_done(n);
    chk("t5_clear_cycles", 64'(n), 64'd32);
    check_all_zero("t5_reg");

    // T6: 64-bit, 16-entry, 3-port, ordinary r0
    chk("t6_done_in_reset", b_done, 1'b0);
    b_rst = 1'b0;
    wait_done_b(n);
    chk("t6_clear_cycles", 64'(n), 64'd16);
    b_we = 1'b1; b_wa = '0; b_wd = '1;
    tick();
    b_wa = BAW'(1); b_wd = 64'h0123_4567_89AB_CDEF;
    tick();
    b_wa = BAW'(2); b_wd = 64'hFEDC_BA98_7654_3210;
    tick();
    b_we = 1'b0;
    b_ra = {4'd0, 4'd2, 4'd1};
    #1;
    chk("t6_port0", b_rdata[BDW-1:0], 64'h0123_4567_89AB_CDEF);
    chk("t6_port1", b_rdata[2*BDW-1:BDW], 64'hFEDC_BA98_7654_3210);
    chk("t6_port2_r0", b_rdata[3*BDW-1:2*BDW], 64'hFFFF_FFFF_FFFF_FFFF);
    b_sb = 1'b1; b_sa = '0;
    tick();
    b_sb = 1'b0;
    #1;
    chk("t6_r0_pending", b_rpend, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
